cnn_state_update: RTL and testbench
===================================

// Module: cnn_state_update
// PURPOSE
//  Sequential state integrator for one cellular-network cell. It produces the 2*WIDTH state X consumed by eq2.
//  Per iteration: streams TAPS (a,y,b,u) tuples, forms acc = sum(a*y + b*u), then computes
//  x += (acc + z - x) >>> SHIFT with saturation.
//  Presents x_out and y_out = eq2(x_out) on a valid/ready output, then repeats ITER times.
// PARAMETERS
//  WIDTH  9   tap operand width (a,y,b,u signed); state/bias width is 2*WIDTH
//  TAPS   9   taps per iteration (3x3 neighbourhood)
//  SHIFT  3   Euler step, dt = 2^-SHIFT (arithmetic right shift)
//  ITER   16  iterations per init transaction, >=1
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  init_valid  in   1        x_init/z_bias valid
//  init_ready  out  1        high only in IDLE
//  x_init      in   2*WIDTH  signed initial state
//  z_bias      in   2*WIDTH  signed bias, held internally for all ITER iterations
//  tap_valid   in   1        tap tuple valid
//  tap_ready   out  1        high only in ACCUM
//  tap_a,tap_y in   WIDTH    signed feedback coefficient / neighbour output
//  tap_b,tap_u in   WIDTH    signed control coefficient / neighbour input
//  out_valid   out  1        x_out/y_out valid
//  out_ready   in   1        consumer accepts
//  x_out       out  2*WIDTH  signed state after update
//  y_out       out  2*WIDTH  eq2(x_out), in {-1, x_out, +1}
//  out_last    out  1        high with out_valid on final iteration
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; x, z, acc, tap_cnt, iter_cnt = 0; all outputs 0 except init_ready=1.
//  FSM: IDLE -> ACCUM -> UPDATE -> OUTPUT -> (ACCUM | IDLE).
//  IDLE: on init_valid&init_ready, x<=x_init, z<=z_bias, acc<=0, tap_cnt<=0, iter_cnt<=0; go ACCUM.
//  ACCUM: each tap_valid&tap_ready: acc += a*y + b*u; tap_cnt++. On the handshake with tap_cnt==TAPS-1, go UPDATE.
//   No handshake means acc is held.
//  UPDATE (1 cycle, no handshake): dx = acc + z - x; x <= sat(x + (dx >>> SHIFT)); acc<=0; tap_cnt<=0. Go OUTPUT.
//  OUTPUT: out_valid=1; x_out, y_out and out_last stay stable until out_ready.
//   On accept, if iter_cnt==ITER-1 go IDLE, else iter_cnt++ and go ACCUM.
//  Widths: products 2*WIDTH. acc is 2*WIDTH+$clog2(2*TAPS) bits. dx has 2 further guard bits. All arithmetic is signed.
//   >>> floors toward -inf (no rounding).
//   sat() clamps to [-2^(2W-1), 2^(2W-1)-1].
//  Latency: final tap handshake -> out_valid = 2 cycles. An init handshake to the first tap_ready takes 1 cycle.
//  x_out is registered state x, driven only in OUTPUT and 0 otherwise. y_out is combinational eq2(x_out).
//  Simultaneous: in OUTPUT, taps are not accepted (tap_ready=0). init_valid is ignored outside IDLE.
// STRUCTURE
//  Shared package: FSM state enum (IDLE, ACCUM, UPDATE, OUTPUT), width helpers ACC_W, DX_W, and SAT_MAX/SAT_MIN constants.
//  Sub-module: instantiates existing eq2 on x_out to drive y_out. The MAC is inline; no other sub-modules.
// TESTING (WIDTH=9, TAPS=9, SHIFT=3)
//  Reset -> init_ready=1, tap_ready=0, out_valid=0, x_out=y_out=0.
//  ITER=1, x_init=0, z=8, all taps 0 -> x_out=1, y_out=1, out_last=1, then IDLE.
//  ITER=1, x_init=16 and x_init=1, z=0, taps 0:
//   x_init=16 -> x_out=14, y_out=1.
//   x_init=1 -> x_out=0 (floor: -1>>>3 = -1), y_out=0.
//  x_init=131071, z=131071, 9 taps a=y=255, b=u=255:
//   acc=1170450, x_out saturates to 131071.
//   All taps at -256/255 mixes -> x_out saturates to -131072.
//  ITER=3, out_ready low 5 cycles each iteration:
//   out_valid/x_out held and tap_ready=0 while stalled.
//   Exactly 3 outputs are produced; out_last is set only on the 3rd.
//  Gapped tap_valid, then rst_n pulsed low mid-ACCUM after 4 taps -> immediate IDLE, all outputs 0.
//   A fresh init then gives the same result as an undisturbed run.

Source files
------------

// File: rtl/cnn_state_update_pkg.sv
// Shared definitions for the cellular-network state integrator: FSM encoding,
// default geometry and the width helpers used to size the MAC and update datapath.
package cnn_state_update_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_TAPS  = 9;
    localparam int DEF_SHIFT = 3;
    localparam int DEF_ITER  = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCUM  = 2'd1;
    localparam state_t ST_UPDATE = 2'd2;
    localparam state_t ST_OUTPUT = 2'd3;

    // Accumulator holds TAPS sums of two 2*WIDTH products without overflow.
    function automatic int acc_w(input int width, input int taps);
        return 2 * width + $clog2(2 * taps);
    endfunction

    // acc + z - x needs two guard bits above the accumulator.
    function automatic int dx_w(input int width, input int taps);
        return acc_w(width, taps) + 2;
    endfunction

    localparam int ACC_W = acc_w(DEF_WIDTH, DEF_TAPS);
    localparam int DX_W  = dx_w(DEF_WIDTH, DEF_TAPS);

    localparam logic signed [2*DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(2*DEF_WIDTH-1){1'b1}}};
    localparam logic signed [2*DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(2*DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/cnn_state_update_eq2.sv
// Piecewise-linear cell output: clamps the integer state to {-1, 0, +1}.
module cnn_state_update_eq2 #(
    parameter int W = 18
) (
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    assign y = x[W-1] ? '1 : ((|x) ? W'(1) : '0);

endmodule

// File: rtl/cnn_state_update.sv
// One cellular-network cell: accumulates a*y + b*u over the neighbourhood, takes an
// Euler step of the state toward acc + z, and streams the saturated state and its output.
module cnn_state_update
    import cnn_state_update_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAPS  = DEF_TAPS,
    parameter int SHIFT = DEF_SHIFT,
    parameter int ITER  = DEF_ITER
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_valid,
    output logic                      init_ready,
    input  logic signed [2*WIDTH-1:0] x_init,
    input  logic signed [2*WIDTH-1:0] z_bias,
    input  logic                      tap_valid,
    output logic                      tap_ready,
    input  logic signed [WIDTH-1:0]   tap_a,
    input  logic signed [WIDTH-1:0]   tap_y,
    input  logic signed [WIDTH-1:0]   tap_b,
    input  logic signed [WIDTH-1:0]   tap_u,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] x_out,
    output logic signed [2*WIDTH-1:0] y_out,
    output logic                      out_last
);

    localparam int XW  = 2 * WIDTH;
    localparam int AW  = acc_w(WIDTH, TAPS);
    localparam int DW  = dx_w(WIDTH, TAPS);
    localparam int TCW = $clog2(TAPS + 1);
    localparam int ICW = $clog2(ITER + 1);
    localparam logic [TCW-1:0] TAP_LAST  = TCW'(TAPS - 1);
    localparam logic [ICW-1:0] ITER_LAST = ICW'(ITER - 1);

    state_t                state;
    logic signed [XW-1:0]  x;
    logic signed [XW-1:0]  z;
    logic signed [AW-1:0]  acc;
    logic [TCW-1:0]        tap_cnt;
    logic [ICW-1:0]        iter_cnt;

    logic signed [XW-1:0]  p_ay;
    logic signed [XW-1:0]  p_bu;
    logic signed [AW-1:0]  acc_next;
    logic signed [DW-1:0]  dx;
    logic signed [DW-1:0]  step;
    logic signed [DW:0]    x_sum;
    logic signed [XW-1:0]  x_sat;
    logic                  sum_fits;

    // NOTE: every combinational output is assigned on every path, so no latch can form.
    always_comb begin
        p_ay     = $signed({{WIDTH{tap_a[WIDTH-1]}}, tap_a}) * $signed({{WIDTH{tap_y[WIDTH-1]}}, tap_y});
        p_bu     = $signed({{WIDTH{tap_b[WIDTH-1]}}, tap_b}) * $signed({{WIDTH{tap_u[WIDTH-1]}}, tap_u});
        acc_next = acc + $signed({{(AW-XW){p_ay[XW-1]}}, p_ay})
                       + $signed({{(AW-XW){p_bu[XW-1]}}, p_bu});
        dx       = $signed({{(DW-AW){acc[AW-1]}}, acc})
                 + $signed({{(DW-XW){z[XW-1]}}, z})
                 - $signed({{(DW-XW){x[XW-1]}}, x});
        step     = dx >>> SHIFT;
        x_sum    = $signed({{(DW+1-XW){x[XW-1]}}, x}) + $signed({step[DW-1], step});
        // The sum fits when every bit above the target sign bit matches it.
        sum_fits = (&x_sum[DW:XW-1]) | ~(|x_sum[DW:XW-1]);
        if (sum_fits) begin
            x_sat = x_sum[XW-1:0];
        end else if (x_sum[DW]) begin
            x_sat = {1'b1, {(XW-1){1'b0}}};
        end else begin
            x_sat = {1'b0, {(XW-1){1'b1}}};
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            x        <= '0;
            z        <= '0;
            acc      <= '0;
            tap_cnt  <= '0;
            iter_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init_valid) begin
                        x        <= x_init;
                        z        <= z_bias;
                        acc      <= '0;
                        tap_cnt  <= '0;
                        iter_cnt <= '0;
                        state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (tap_valid) begin
                        acc     <= acc_next;
                        tap_cnt <= tap_cnt + TCW'(1);
                        if (tap_cnt == TAP_LAST) state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    x       <= x_sat;
                    acc     <= '0;
                    tap_cnt <= '0;
                    state   <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        if (iter_cnt == ITER_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            iter_cnt <= iter_cnt + ICW'(1);
                            state    <= ST_ACCUM;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign init_ready = (state == ST_IDLE);
    assign tap_ready  = (state == ST_ACCUM);
    assign out_valid  = (state == ST_OUTPUT);
    assign x_out      = out_valid ? x : '0;
    assign out_last   = out_valid && (iter_cnt == ITER_LAST);

    cnn_state_update_eq2 #(.W(XW)) u_eq2 (
        .x (x_out),
        .y (y_out)
    );

endmodule

// File: tb/tb_cnn_state_update.sv
// Directed bench for cnn_state_update: a single-iteration and a three-iteration
// instance share stimulus, with a reference model feeding an expected-result queue.
module tb_cnn_state_update;

    localparam int W  = 9;
    localparam int XW = 18;

    typedef struct {
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic               last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  sel;
    logic                  init_valid;
    logic signed [XW-1:0]  x_init;
    logic signed [XW-1:0]  z_bias;
    logic                  tap_valid;
    logic signed [W-1:0]   tap_a, tap_y, tap_b, tap_u;
    logic                  out_ready;

    logic                  iv[2], tv[2], orr[2];
    logic                  ir[2], tr[2], ov[2], ol[2];
    logic signed [XW-1:0]  xo[2], yo[2];

    logic                  init_ready, tap_ready, out_valid, out_last;
    logic signed [XW-1:0]  x_out, y_out;

    assign iv[0]  = init_valid & ~sel;
    assign iv[1]  = init_valid & sel;
    assign tv[0]  = tap_valid & ~sel;
    assign tv[1]  = tap_valid & sel;
    assign orr[0] = out_ready & ~sel;
    assign orr[1] = out_ready & sel;

    always_comb begin
        init_ready = sel ? ir[1] : ir[0];
        tap_ready  = sel ? tr[1] : tr[0];
        out_valid  = sel ? ov[1] : ov[0];
        out_last   = sel ? ol[1] : ol[0];
        x_out      = sel ? xo[1] : xo[0];
        y_out      = sel ? yo[1] : yo[0];
    end

    cnn_state_update #(.WIDTH(W), .TAPS(9), .SHIFT(3), .ITER(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .init_valid(iv[0]), .init_ready(ir[0]), .x_init(x_init), .z_bias(z_bias),
        .tap_valid(tv[0]), .tap_ready(tr[0]),
        .tap_a(tap_a), .tap_y(tap_y), .tap_b(tap_b), .tap_u(tap_u),
        .out_valid(ov[0]), .out_ready(orr[0]), .x_out(xo[0]), .y_out(yo[0]), .out_last(ol[0])
    );

    cnn_state_update #(.WIDTH(W), .TAPS(9), .SHIFT(3), .ITER(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .init_valid(iv[1]), .init_ready(ir[1]), .x_init(x_init), .z_bias(z_bias),
        .tap_valid(tv[1]), .tap_ready(tr[1]),
        .tap_a(tap_a), .tap_y(tap_y), .tap_b(tap_b), .tap_u(tap_u),
        .out_valid(ov[1]), .out_ready(orr[1]), .x_out(xo[1]), .y_out(yo[1]), .out_last(ol[1])
    );

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int ta[9], ty[9], tb[9], tu[9];
    logic signed [63:0] x_m, z_m;
    exp_t sb[$];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference Euler step: floor division by 8, then clamp to the 18-bit signed range.
    function automatic logic signed [63:0] model_update(input logic signed [63:0] x,
                                                        input logic signed [63:0] z,
                                                        input logic signed [63:0] acc);
        logic signed [63:0] dx, q, nx;
        dx = acc + z - x;
        if (dx >= 0) q = dx / 8;
        else         q = -((-dx + 7) / 8);
        nx = x + q;
        if (nx > 131071)       nx = 131071;
        else if (nx < -131072) nx = -131072;
        return nx;
    endfunction

    function automatic logic signed [63:0] model_y(input logic signed [63:0] x);
        if (x > 0)      return 1;
        else if (x < 0) return -1;
        else            return 0;
    endfunction

    task automatic fill_const(input int a, input int y, input int b, input int u);
        for (int i = 0; i < 9; i++) begin
            ta[i] = a; ty[i] = y; tb[i] = b; tu[i] = u;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 9; i++) begin
            ta[i] = int'($urandom_range(0, 511)) - 256;
            ty[i] = int'($urandom_range(0, 511)) - 256;
            tb[i] = int'($urandom_range(0, 511)) - 256;
            tu[i] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; init_valid = 1'b0; tap_valid = 1'b0; out_ready = 1'b0;
        x_init = '0; z_bias = '0; tap_a = '0; tap_y = '0; tap_b = '0; tap_u = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_init(input logic signed [63:0] x0, input logic signed [63:0] z0);
        int n;
        x_init = x0[XW-1:0];
        z_bias = z0[XW-1:0];
        init_valid = 1'b1;
        n = 0;
        while (!init_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("init_ready", init_ready, 1);
        @(negedge clk);
        init_valid = 1'b0;
        check("init_to_tap_ready", tap_ready, 1);
        x_m = x0;
        z_m = z0;
    endtask

    task automatic send_taps(input int count, input int gap);
        int n;
        for (int i = 0; i < count; i++) begin
            if (gap > 0) begin
                repeat ($urandom_range(0, gap)) begin
                    tap_valid = 1'b0;
                    tap_a = W'($urandom); tap_y = W'($urandom);
                    tap_b = W'($urandom); tap_u = W'($urandom);
                    @(negedge clk);
                end
            end
            tap_valid = 1'b1;
            tap_a = ta[i][W-1:0]; tap_y = ty[i][W-1:0];
            tap_b = tb[i][W-1:0]; tap_u = tu[i][W-1:0];
            n = 0;
            while (!tap_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("tap_ready", tap_ready, 1);
            @(negedge clk);
        end
        tap_valid = 1'b0;
    endtask

    task automatic run_iter(input int gap, input int stall, input logic last);
        logic signed [63:0] acc;
        exp_t e;
        int cnt;
        acc = 0;
        for (int i = 0; i < 9; i++) acc += longint'(ta[i]) * ty[i] + longint'(tb[i]) * tu[i];
        x_m = model_update(x_m, z_m, acc);
        e.x = x_m; e.y = model_y(x_m); e.last = last;
        sb.push_back(e);

        send_taps(9, gap);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("tap_to_out_latency", cnt, 2);

        for (int s = 0; s < stall; s++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_tap_ready", tap_ready, 0);
            check("stall_x_out", x_out, sb[0].x);
            @(negedge clk);
        end

        out_ready = 1'b1;
        e = sb.pop_front();
        check("out_valid", out_valid, 1);
        check("x_out", x_out, e.x);
        check("y_out", y_out, e.y);
        check("out_last", out_last, e.last);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_init_ready"}, init_ready, 1);
        check({tag, "_tap_ready"}, tap_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_x_out"}, x_out, 0);
        check({tag, "_y_out"}, y_out, 0);
        check({tag, "_out_last"}, out_last, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0;
        do_reset();
        check_idle("reset");

        // Single-iteration instance: bias pull-up, decay, floor on negative step.
        fill_const(0, 0, 0, 0);
        do_init(0, 8);
        run_iter(0, 0, 1'b1);
        check_idle("after_iter1");

        do_init(16, 0);
        run_iter(0, 0, 1'b1);
        do_init(1, 0);
        run_iter(0, 0, 1'b1);

        // Saturation at both ends of the state range.
        fill_const(255, 255, 255, 255);
        do_init(131071, 131071);
        run_iter(0, 0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            ta[i] = (i % 2 == 0) ? -256 : 255;
            ty[i] = (i % 2 == 0) ? 255 : -256;
            tb[i] = -256;
            tu[i] = 255;
        end
        do_init(-131072, -131072);
        run_iter(1, 0, 1'b1);

        // Three-iteration instance with back-pressure on every output.
        sel = 1'b1;
        @(negedge clk);
        do_init(1000, -2000);
        for (int k = 0; k < 3; k++) begin
            fill_rand();
            run_iter(1, 5, (k == 2));
            if (k < 2) check("next_iter_tap_ready", tap_ready, 1);
        end
        check_idle("after_iter3");

        // Reset in the middle of accumulation, then a clean rerun.
        sel = 1'b0;
        @(negedge clk);
        fill_rand();
        do_init(500, -300);
        send_taps(4, 2);
        #2 rst_n = 1'b0;
        #1 check_idle("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_init(500, -300);
        run_iter(2, 0, 1'b1);
        check_idle("after_rerun");

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
